// File: rtl/scc_mem_dump_writer_pkg.sv
// scc_mem_dump_writer_pkg: shared states, widths and record type for the memory dump writer
package scc_mem_dump_writer_pkg;
  localparam int SCC_WORD_W = 32;
  localparam int SCC_MEM_BYTES = 1 << 16;
  localparam int REC_ADDR_W = 32;
  localparam int REC_VALUE_W = 32;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;
  typedef struct packed {
    logic [REC_ADDR_W-1:0]  addr;
    logic [REC_VALUE_W-1:0] value;
    logic                   last;
  } rec_t;
endpackage

// File: rtl/scc_mem_dump_writer_out_reg.sv
// scc_mem_dump_writer_out_reg: one-entry record register that holds its contents until taken
module scc_mem_dump_writer_out_reg
  import scc_mem_dump_writer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic rdy,
  input  rec_t d,
  output logic v,
  output rec_t q
);
  // a load wins over a take so a record can be replaced in the cycle it is accepted
  always_ff @(posedge clk)
    if (rst) begin
      v <= 1'b0;
      q <= '0;
    end else if (ld) begin
      v <= 1'b1;
      q <= d;
    end else if (v && rdy) v <= 1'b0;
endmodule

// File: rtl/scc_mem_dump_writer.sv
// scc_mem_dump_writer: on SCC halt, streams data memory as (addr,value) records; SCC_DUMP_SKIP_ZERO_EN drops zero words
module scc_mem_dump_writer
  import scc_mem_dump_writer_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 16'hFFFC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt_f,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_rd_addr,
  input  logic [SCC_WORD_W-1:0]  mem_rd_data,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [REC_ADDR_W-1:0]  rec_addr,
  output logic [REC_VALUE_W-1:0] rec_value,
  output logic                   rec_last,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      rec_count
);
  state_t state, nxt;
  logic [ADDR_W:0] cnt;
  logic halt_q, halt_edge, hs, at_end, cnt_inc, out_ld;
  logic [REC_ADDR_W-1:0] cur_addr;
  rec_t out_in, out_q;
`ifdef SCC_DUMP_SKIP_ZERO_EN
  logic pend_ld, pend_take, pend_v, nz;
  rec_t pend_q;
  assign nz = mem_rd_data != '0;
  scc_mem_dump_writer_out_reg u_pend (
    .clk (clk),
    .rst (rst),
    .ld  (pend_ld),
    .rdy (pend_take),
    .d   ('{addr: cur_addr, value: mem_rd_data, last: 1'b0}),
    .v   (pend_v),
    .q   (pend_q)
  );
`endif
  assign halt_edge = halt_f && !halt_q;
  assign hs = rec_valid && rec_ready;
  assign at_end = cnt == {1'b0, END_ADDR};
  assign cur_addr = REC_ADDR_W'(cnt[ADDR_W-1:0]);
  assign mem_rd_en = state == S_RD;
  assign mem_rd_addr = mem_rd_en ? cnt[ADDR_W-1:0] : '0;
  assign busy = state inside {S_RD, S_WT, S_EMIT};
  assign done = state == S_DONE;
  assign rec_addr = out_q.addr;
  assign rec_value = out_q.value;
  assign rec_last = rec_valid && out_q.last;
  scc_mem_dump_writer_out_reg u_out (
    .clk (clk),
    .rst (rst),
    .ld  (out_ld),
    .rdy (rec_ready),
    .d   (out_in),
    .v   (rec_valid),
    .q   (out_q)
  );
  // state, extra-wide address counter, halt history and accepted-record count
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      cnt <= {1'b0, START_ADDR};
      halt_q <= halt_f;
      rec_count <= '0;
    end else begin
      state <= nxt;
      halt_q <= halt_f;
      if (cnt_inc) cnt <= cnt + (ADDR_W+1)'(4);
      if (hs) rec_count <= rec_count + ADDR_W'(1);
    end
  // next state, counter advance and record loads; a held zero-skip capture is flushed as last at the end
  always_comb begin
    nxt = state;
    cnt_inc = 1'b0;
    out_ld = 1'b0;
    out_in = '{addr: cur_addr, value: mem_rd_data, last: at_end};
`ifdef SCC_DUMP_SKIP_ZERO_EN
    pend_ld = 1'b0;
    pend_take = 1'b0;
`endif
    case (state)
      S_IDLE: nxt = halt_edge ? S_RD : S_IDLE;
      S_RD: nxt = S_WT;
      S_WT: begin
`ifdef SCC_DUMP_SKIP_ZERO_EN
        if (nz && pend_v) begin
          out_ld = 1'b1;
          out_in = '{addr: pend_q.addr, value: pend_q.value, last: 1'b0};
          pend_ld = 1'b1;
          nxt = S_EMIT;
        end else if (nz && at_end) begin
          out_ld = 1'b1;
          nxt = S_EMIT;
        end else if (nz) begin
          pend_ld = 1'b1;
          cnt_inc = 1'b1;
          nxt = S_RD;
        end else if (at_end && pend_v) begin
          out_ld = 1'b1;
          out_in = '{addr: pend_q.addr, value: pend_q.value, last: 1'b1};
          pend_take = 1'b1;
          nxt = S_EMIT;
        end else if (at_end) nxt = S_DONE;
        else begin
          cnt_inc = 1'b1;
          nxt = S_RD;
        end
`else
        out_ld = 1'b1;
        nxt = S_EMIT;
`endif
      end
      S_EMIT: if (hs) begin
`ifdef SCC_DUMP_SKIP_ZERO_EN
        if (rec_last) nxt = S_DONE;
        else if (at_end) begin
          out_ld = 1'b1;
          out_in = '{addr: pend_q.addr, value: pend_q.value, last: 1'b1};
          pend_take = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          nxt = S_RD;
        end
`else
        nxt = at_end ? S_DONE : S_RD;
        cnt_inc = !at_end;
`endif
      end
      S_DONE: nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_scc_mem_dump_writer.sv
// tb_scc_mem_dump_writer: randomized dump runs checked against a list-based model of the expected record stream
module tb_scc_mem_dump_writer;
  import scc_mem_dump_writer_pkg::*;
  localparam int A_START = 32'h0000;
  localparam int A_END = 32'h000C;
  localparam int B_ADDR = 32'hFFFC;
`ifdef SCC_DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk_tb = 1'b0;
  logic rst = 1'b1;
  logic halt_a = 1'b0, halt_b = 1'b0;
  logic rec_ready_a = 1'b1, rec_ready_b = 1'b1;
  logic mem_rd_en_a, mem_rd_en_b;
  logic [15:0] mem_rd_addr_a, mem_rd_addr_b, rec_count_a, rec_count_b;
  logic [31:0] rd_data_a, rd_data_b, rec_addr_a, rec_addr_b, rec_value_a, rec_value_b;
  logic rec_valid_a, rec_valid_b, rec_last_a, rec_last_b;
  logic busy_a, busy_b, done_a, done_b;
  logic [31:0] mem [SCC_MEM_BYTES/4];
  int total = 0, bad = 0, rdy_mode = 0, stall = 0;
  rec_t obs[$];
  rec_t exp_q[$];
  logic have_prev = 1'b0;
  logic [31:0] prev_addr, prev_value;

  always #5 clk_tb = ~clk_tb;

  scc_mem_dump_writer #(.ADDR_W(16), .START_ADDR(16'(A_START)), .END_ADDR(16'(A_END))) dut_a (
    .clk(clk_tb), .rst(rst), .halt_f(halt_a),
    .mem_rd_en(mem_rd_en_a), .mem_rd_addr(mem_rd_addr_a), .mem_rd_data(rd_data_a),
    .rec_valid(rec_valid_a), .rec_ready(rec_ready_a), .rec_addr(rec_addr_a),
    .rec_value(rec_value_a), .rec_last(rec_last_a), .busy(busy_a), .done(done_a),
    .rec_count(rec_count_a)
  );

  scc_mem_dump_writer #(.ADDR_W(16), .START_ADDR(16'(B_ADDR)), .END_ADDR(16'(B_ADDR))) dut_b (
    .clk(clk_tb), .rst(rst), .halt_f(halt_b),
    .mem_rd_en(mem_rd_en_b), .mem_rd_addr(mem_rd_addr_b), .mem_rd_data(rd_data_b),
    .rec_valid(rec_valid_b), .rec_ready(rec_ready_b), .rec_addr(rec_addr_b),
    .rec_value(rec_value_b), .rec_last(rec_last_b), .busy(busy_b), .done(done_b),
    .rec_count(rec_count_b)
  );

  // synchronous-read data memory shared by both writers
  always @(posedge clk_tb) begin
    if (mem_rd_en_a) rd_data_a <= mem[mem_rd_addr_a[15:2]];
    if (mem_rd_en_b) rd_data_b <= mem[mem_rd_addr_b[15:2]];
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk_tb);
    #1;
  endtask

  // sink ready: 0 tied high, 1 random, 2 low for 5 cycles on each record
  initial forever begin
    @(posedge clk_tb);
    #1;
    if (rdy_mode == 0) rec_ready_a = 1'b1;
    else if (rdy_mode == 1) rec_ready_a = 1'($urandom_range(0, 1));
    else if (rec_valid_a && stall == 5) begin
      rec_ready_a = 1'b1;
      stall = 0;
    end else begin
      rec_ready_a = 1'b0;
      stall = rec_valid_a ? stall + 1 : 0;
    end
  end

  // stream monitor: collect accepted records and require stable data while stalled
  initial forever begin
    @(negedge clk_tb);
    if (rst) have_prev = 1'b0;
    else begin
      if (have_prev) begin
        chk("hold_valid", rec_valid_a, 1);
        chk("hold_addr", rec_addr_a, prev_addr);
        chk("hold_value", rec_value_a, prev_value);
      end
      have_prev = rec_valid_a && !rec_ready_a;
      prev_addr = rec_addr_a;
      prev_value = rec_value_a;
      if (rec_valid_a && rec_ready_a)
        obs.push_back('{addr: rec_addr_a, value: rec_value_a, last: rec_last_a});
    end
  end

  task automatic build_exp();
    exp_q.delete();
    for (int a = A_START; a <= A_END; a += 4)
      if (!SKIP || mem[a>>2] != 0) exp_q.push_back('{addr: 32'(a), value: mem[a>>2], last: 1'b0});
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    obs.delete();
  endtask

  task automatic chk_zero_a(string tag);
    chk({tag, "_valid"}, rec_valid_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_count"}, rec_count_a, 0);
    chk({tag, "_rd_en"}, mem_rd_en_a, 0);
    chk({tag, "_rd_addr"}, mem_rd_addr_a, 0);
    chk({tag, "_addr"}, rec_addr_a, 0);
    chk({tag, "_value"}, rec_value_a, 0);
    chk({tag, "_last"}, rec_last_a, 0);
  endtask

  task automatic check_dump(string name);
    build_exp();
    chk({name, "_nrec"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      chk({name, "_addr"}, obs[i].addr, exp_q[i].addr);
      chk({name, "_value"}, obs[i].value, exp_q[i].value);
      chk({name, "_last"}, obs[i].last, exp_q[i].last);
    end
    chk({name, "_rec_count"}, rec_count_a, exp_q.size());
    chk({name, "_done"}, done_a, 1);
    chk({name, "_busy"}, busy_a, 0);
    chk({name, "_valid"}, rec_valid_a, 0);
  endtask

  task automatic run_dump(string name, int mode, bit lat);
    obs.delete();
    rdy_mode = mode;
    halt_a = 1'b1;
    tick(1);
    halt_a = 1'b0;
    if (lat) begin
      chk({name, "_rd_en"}, mem_rd_en_a, 1);
      chk({name, "_rd_addr"}, mem_rd_addr_a, A_START);
      chk({name, "_busy_rd"}, busy_a, 1);
`ifndef SCC_DUMP_SKIP_ZERO_EN
      tick(1);
      chk({name, "_lat_wt"}, rec_valid_a, 0);
      tick(1);
      chk({name, "_lat_emit"}, rec_valid_a, 1);
      chk({name, "_first_addr"}, rec_addr_a, A_START);
`endif
    end
    for (int i = 0; i < 3000 && !done_a; i++) tick(1);
    check_dump(name);
  endtask

  task automatic load_basic();
    mem[0] = 32'h11223344;
    mem[1] = 32'h0;
    mem[2] = 32'hDEADBEEF;
    mem[3] = 32'h00000001;
  endtask

  initial begin
    int nb;
    logic [31:0] last_ba, last_bv, last_bl;
    for (int i = 0; i < SCC_MEM_BYTES/4; i++) mem[i] = 32'h0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_zero_a("reset");
      chk("reset_rd_en_b", mem_rd_en_b, 0);
    end
    rst = 1'b0;
    tick(4);
    chk_zero_a("idle");
    load_basic();
    run_dump("basic", 0, 1'b1);
    halt_a = 1'b1;
    tick(5);
    halt_a = 1'b0;
    chk("done_ignore_busy", busy_a, 0);
    chk("done_ignore_count", rec_count_a, SKIP ? 3 : 4);
    chk("done_sticky", done_a, 1);
    do_reset();
    run_dump("backpressure", 2, 1'b0);
    halt_a = 1'b1;
    do_reset();
    tick(5);
    chk("halt_at_reset_busy", busy_a, 0);
    chk("halt_at_reset_rd_en", mem_rd_en_a, 0);
    halt_a = 1'b0;
    tick(1);
    obs.delete();
    rdy_mode = 2;
    halt_a = 1'b1;
    for (int i = 0; i < 200 && obs.size() < 1; i++) tick(1);
    halt_a = 1'b0;
    for (int i = 0; i < 200 && !(rec_valid_a && obs.size() == 1); i++) tick(1);
    chk("mid_second_valid", rec_valid_a, 1);
    rst = 1'b1;
    tick(1);
    chk_zero_a("mid_rst");
    rst = 1'b0;
    tick(1);
    run_dump("restart", 0, 1'b1);
    for (int w = 0; w < 4; w++) mem[w] = 32'h0;
    do_reset();
    run_dump("all_zero", 1, 1'b0);
    for (int t = 0; t < 8; t++) begin
      for (int w = 0; w < 4; w++) mem[w] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      do_reset();
      run_dump("rand", $urandom_range(0, 2), 1'b0);
    end
    mem[B_ADDR>>2] = 32'hCAFEF00D;
    mem[0] = 32'h0BADBAD0;
    do_reset();
    nb = 0;
    last_ba = '0;
    last_bv = '0;
    last_bl = '0;
    halt_b = 1'b1;
    tick(1);
    halt_b = 1'b0;
    for (int i = 0; i < 200 && !done_b; i++) begin
      @(negedge clk_tb);
      if (mem_rd_en_b) chk("upper_rd_addr", mem_rd_addr_b, B_ADDR);
      if (rec_valid_b && rec_ready_b) begin
        nb++;
        last_ba = rec_addr_b;
        last_bv = rec_value_b;
        last_bl = rec_last_b;
      end
    end
    tick(10);
    chk("upper_nrec", nb, 1);
    chk("upper_addr", last_ba, 32'h0000FFFC);
    chk("upper_value", last_bv, 32'hCAFEF00D);
    chk("upper_last", last_bl, 1);
    chk("upper_done", done_b, 1);
    chk("upper_busy", busy_b, 0);
    chk("upper_count", rec_count_b, 1);
    chk("upper_valid", rec_valid_b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
